// File: rtl/glitch_sequencer_pkg.sv
// Shared definitions for the glitch sequencer: FSM state encoding, bit
// positions of the fields in a glitch-setting word, and default parameter
// values used by the top level.
package glitch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_RESET_TGT = 3'd3,
    ST_WAIT_RDY  = 3'd4,
    ST_DELAY     = 3'd5,
    ST_GLITCH    = 3'd6,
    ST_GAP       = 3'd7
  } state_e;

  // Glitch-setting word layout
  localparam int DELAY_LSB    = 0;
  localparam int DELAY_MSB    = 19;
  localparam int WIDTH_LSB    = 20;
  localparam int WIDTH_MSB    = 29;
  localparam int RST_TGT_BIT  = 30;
  localparam int WAIT_RDY_BIT = 31;

  // Default parameter values
  localparam int DEF_DELAY_W        = DELAY_MSB - DELAY_LSB + 1;
  localparam int DEF_WIDTH_W        = WIDTH_MSB - WIDTH_LSB + 1;
  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1048575;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/glitch_seq_cnt.sv
// Loadable down-counter with zero and last-count flags. Load has priority
// over decrement; the counter saturates at zero so it can never wrap.
module glitch_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // Count register: load a new period or step down towards zero
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/glitch_sequencer.sv
// Glitch sequencer: reads glitch-setting words from the FIFO read port and
// turns each one into a timed attempt (optional target reset, optional wait
// for board-ready, delay, glitch pulse, inter-glitch gap).
// Optional feature: define GLITCH_SEQ_TIMEOUT_EN to add a board-ready
// watchdog with a sticky timeout flag; otherwise WAIT_RDY waits forever.
module glitch_sequencer
  import glitch_sequencer_pkg::*;
#(
  parameter int DELAY_W    = DEF_DELAY_W,
  parameter int WIDTH_W    = DEF_WIDTH_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
`ifdef GLITCH_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_re,
  input  logic        board_ready,
  output logic        ready,
  output logic        busy,
  output logic        rst_o,
  output logic        delay_en,
  output logic        glitch_en,
  output logic [15:0] glitch_cnt,
  output logic        timeout
);

`ifdef GLITCH_SEQ_TIMEOUT_EN
  localparam int TMR_MAX = max_int(max_int(RST_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int TMR_MAX = max_int(RST_CYCLES, GAP_CYCLES);
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  state_e       r_state;
  state_e       w_state_nxt;
  state_e       w_after_wait;
  state_e       w_after_rst;
  logic         r_rst_tgt;
  logic         r_wait_rdy;
  logic         r_rst_o;
  logic         r_delay_en;
  logic         r_glitch_en;
  logic         r_busy;
  logic         r_ready;
  logic [15:0]  r_glitch_cnt;
  logic         w_fifo_re;
  logic         w_fetch;
  logic         w_dly_zero;
  logic         w_dly_last;
  logic         w_wid_zero;
  logic         w_wid_last;
  logic         w_tmr_zero;
  logic         w_tmr_last;
  logic         w_tmr_done;
  logic         w_tmr_load;
  logic         w_tmr_dec;
  logic [TMR_W-1:0] w_tmr_val;
`ifdef GLITCH_SEQ_TIMEOUT_EN
  logic         w_timeout_set;
  logic         r_timeout;
`endif

  assign w_fetch    = (r_state == ST_FETCH);
  assign w_tmr_done = w_tmr_last | w_tmr_zero;

  // Delay and width counters are loaded while fifo_q is valid in FETCH
  glitch_seq_cnt #(.W(DELAY_W)) u_delay_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_fetch),
    .i_load_val (fifo_q[DELAY_LSB +: DELAY_W]),
    .i_dec      (r_state == ST_DELAY),
    .o_zero     (w_dly_zero),
    .o_last     (w_dly_last)
  );

  glitch_seq_cnt #(.W(WIDTH_W)) u_width_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_fetch),
    .i_load_val (fifo_q[WIDTH_LSB +: WIDTH_W]),
    .i_dec      (r_state == ST_GLITCH),
    .o_zero     (w_wid_zero),
    .o_last     (w_wid_last)
  );

  // Shared timer for target reset, gap and (optionally) the watchdog
  glitch_seq_cnt #(.W(TMR_W)) u_tmr_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero),
    .o_last     (w_tmr_last)
  );

  // Next-state, FIFO strobe and timer control
  always_comb begin
    w_state_nxt  = r_state;
    w_fifo_re    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_tmr_dec    = 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
    w_timeout_set = 1'b0;
`endif
    // Zero delay skips DELAY; zero width skips GLITCH as well
    w_after_wait = w_dly_zero ? (w_wid_zero ? ST_GAP : ST_GLITCH) : ST_DELAY;
    w_after_rst  = r_wait_rdy ? ST_WAIT_RDY : w_after_wait;

    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          w_fifo_re   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH:  w_state_nxt = ST_LATCH;
      ST_LATCH:  w_state_nxt = r_rst_tgt ? ST_RESET_TGT : w_after_rst;
      ST_RESET_TGT: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_done) w_state_nxt = w_after_rst;
      end
      ST_WAIT_RDY: begin
`ifdef GLITCH_SEQ_TIMEOUT_EN
        w_tmr_dec = 1'b1;
        if (board_ready) begin
          w_state_nxt = w_after_wait;
        end else if (w_tmr_done) begin
          w_state_nxt   = ST_GAP;
          w_timeout_set = 1'b1;
        end
`else
        if (board_ready) w_state_nxt = w_after_wait;
`endif
      end
      ST_DELAY: begin
        if (w_dly_last) w_state_nxt = w_wid_zero ? ST_GAP : ST_GLITCH;
      end
      ST_GLITCH: begin
        if (w_wid_last) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Reload the shared timer on entry to each timed state
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_RESET_TGT: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(RST_CYCLES);
        end
        ST_GAP: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(GAP_CYCLES);
        end
`ifdef GLITCH_SEQ_TIMEOUT_EN
        ST_WAIT_RDY: begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(TIMEOUT_CYCLES);
        end
`endif
        default: w_tmr_load = 1'b0;
      endcase
    end
  end

  // State register and registered (glitch-free) control outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_rst_o      <= 1'b0;
      r_delay_en   <= 1'b0;
      r_glitch_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
      r_glitch_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rst_o     <= (w_state_nxt == ST_RESET_TGT);
      r_delay_en  <= (w_state_nxt == ST_DELAY);
      r_glitch_en <= (w_state_nxt == ST_GLITCH);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_ready     <= (w_state_nxt == ST_IDLE) && fifo_empty;
      if ((r_state == ST_GLITCH) && w_wid_last) begin
        r_glitch_cnt <= r_glitch_cnt + 16'd1;
      end
    end
  end

  // Word flags captured while fifo_q is valid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rst_tgt  <= 1'b0;
      r_wait_rdy <= 1'b0;
    end else if (w_fetch) begin
      r_rst_tgt  <= fifo_q[RST_TGT_BIT];
      r_wait_rdy <= fifo_q[WAIT_RDY_BIT];
    end
  end

`ifdef GLITCH_SEQ_TIMEOUT_EN
  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_set) begin
      r_timeout <= 1'b1;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // The read strobe is combinational so it can never fire into an empty FIFO;
  // gating with the reset keeps it low while reset is held.
  assign fifo_re    = w_fifo_re & rst_i;
  assign ready      = r_ready;
  assign busy       = r_busy;
  assign rst_o      = r_rst_o;
  assign delay_en   = r_delay_en;
  assign glitch_en  = r_glitch_en;
  assign glitch_cnt = r_glitch_cnt;

endmodule
